// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: read-side consumer for the 8-bit async FIFO, running in the read clock domain.
// Pops bytes from the FIFO read port, absorbing its 1-cycle registered dout latency, and
// packs PACK_N bytes little-endian into one word on a valid/ready stream. A flush pulse
// drains a partial word with a byte-keep mask.
//
// Ports:
//   clk, rst            read clock; asynchronous active-high reset
//   fifo_empty          FIFO empty flag (read domain)
//   fifo_dout           FIFO data, valid the cycle after a pop
//   fifo_rd_en          pop request to the FIFO
//   m_data, m_keep      packed word (byte0 = first byte popped) and byte-valid mask
//   m_valid, m_ready    output stream handshake
//   flush               1-cycle request to emit the partial word
//   flush_busy          flush in progress
//   flush_done          1-cycle pulse when the flush completes
//   words_out           count of accepted words, wraps modulo 2^CNT_W
module fifo_rd_packer #(
    parameter int unsigned PACK_N = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fifo_empty,
    input  logic [7:0]          fifo_dout,
    output logic                fifo_rd_en,
    output logic [8*PACK_N-1:0] m_data,
    output logic [PACK_N-1:0]   m_keep,
    output logic                m_valid,
    input  logic                m_ready,
    input  logic                flush,
    output logic                flush_busy,
    output logic                flush_done,
    output logic [CNT_W-1:0]    words_out
);

    localparam int unsigned      CntW       = $clog2(PACK_N + 1);
    localparam logic [CntW-1:0]  CntFull    = CntW'(PACK_N);
    localparam logic [CntW:0]    CntFullExt = (CntW + 1)'(PACK_N);

    typedef enum logic [1:0] {StFill, StFlush, StDone} state_e;

    state_e              state_q, state_d;
    logic [8*PACK_N-1:0] acc_q, acc_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                inflight_q;
    logic [8*PACK_N-1:0] data_q, data_d;
    logic [PACK_N-1:0]   keep_q, keep_d;
    logic                valid_q, valid_d;
    logic [CNT_W-1:0]    words_q, words_d;

    logic [CntW:0] pending;
    logic          can_load;
    logic          full_xfer;
    logic          part_xfer;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        keep_d  = keep_q;
        valid_d = valid_q;
        words_d = words_q;

        // Bytes already captured plus the one still on its way must fit in the word.
        pending    = {1'b0, cnt_q} + {{CntW{1'b0}}, inflight_q};
        fifo_rd_en = !rst && !fifo_empty && (state_q == StFill) && (pending < CntFullExt);

        can_load  = !valid_q || m_ready;
        full_xfer = (cnt_q == CntFull) && can_load;
        part_xfer = (state_q == StFlush) && !inflight_q && (cnt_q != '0)
                    && (cnt_q != CntFull) && can_load;

        // A capture never coincides with a transfer: inflight implies cnt < PACK_N.
        if (inflight_q) begin
            for (int i = 0; i < int'(PACK_N); i++) begin
                if (cnt_q == CntW'(i)) begin
                    acc_d[8*i +: 8] = fifo_dout;
                end
            end
            cnt_d = cnt_q + 1'b1;
        end

        if (valid_q && m_ready) begin
            valid_d = 1'b0;
            words_d = words_q + 1'b1;
        end

        if (full_xfer) begin
            data_d  = acc_q;
            keep_d  = '1;
            valid_d = 1'b1;
            cnt_d   = '0;
        end else if (part_xfer) begin
            // Stale bytes above cnt are zeroed rather than exposed.
            for (int i = 0; i < int'(PACK_N); i++) begin
                if (CntW'(i) < cnt_q) begin
                    data_d[8*i +: 8] = acc_q[8*i +: 8];
                    keep_d[i]        = 1'b1;
                end else begin
                    data_d[8*i +: 8] = 8'h00;
                    keep_d[i]        = 1'b0;
                end
            end
            valid_d = 1'b1;
            cnt_d   = '0;
        end

        unique case (state_q)
            StFill: begin
                if (flush) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (!inflight_q && ((cnt_q == '0) || full_xfer || part_xfer)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = flush ? StFlush : StFill;
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StFill;
            acc_q      <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            data_q     <= '0;
            keep_q     <= '0;
            valid_q    <= 1'b0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            inflight_q <= fifo_rd_en;
            data_q     <= data_d;
            keep_q     <= keep_d;
            valid_q    <= valid_d;
            words_q    <= words_d;
        end
    end

    assign m_data     = data_q;
    assign m_keep     = keep_q;
    assign m_valid    = valid_q;
    assign words_out  = words_q;
    assign flush_busy = (state_q == StFlush);
    assign flush_done = (state_q == StDone);

endmodule
